// File: rtl/fetch_buffer_pkg.sv
// Shared types and sizing for the fetch-to-decode decoupling queue.
package fetch_buffer_pkg;

  localparam int unsigned N        = 32;
  localparam int unsigned FB_DEPTH = 4;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch/decode bundle: the fetch and decode stages drive the master side, the queue the slave.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned Len   = N,
  parameter int unsigned Depth = FB_DEPTH
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Len-1:0]  if_pc;
  logic [Len-1:0]  if_instr;
  logic            brTaken;
  logic            freeze;
  logic            id_valid;
  logic [Len-1:0]  id_pc;
  logic [Len-1:0]  id_instr;
  logic            id_ready;
  logic [CntW-1:0] count;

  modport master (
    output if_pc, if_instr, brTaken, id_ready,
    input  freeze, id_valid, id_pc, id_instr, count
  );

  modport slave (
    input  if_pc, if_instr, brTaken, id_ready,
    output freeze, id_valid, id_pc, id_instr, count
  );

endinterface

// File: rtl/fetch_buffer_fifo_ptr_ctrl.sv
// Read/write pointers and occupancy for a power-of-two circular queue with synchronous flush.
module fifo_ptr_ctrl #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic [PtrW-1:0] o_wr_ptr,
  output logic [PtrW-1:0] o_rd_ptr,
  output logic [CntW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);

  // Guard against overflow/underflow even if the caller forgets to gate.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: queues {PC, instr} pairs between fetch and decode, freezes fetch when full,
// and drops all queued wrong-path entries on a taken branch.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned Depth = FB_DEPTH
) (
  input logic           clk,
  input logic           rstn,
  fetch_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic            w_push;
  logic            w_pop;
  logic [PtrW-1:0] w_wr_ptr;
  logic [PtrW-1:0] w_rd_ptr;
  logic [CntW-1:0] w_count;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    r_mem [Depth];

  // Flush wins over both handshakes; freeze comes only from registered occupancy.
  assign w_push = !w_full && !bus.brTaken;
  assign w_pop  = !w_empty && bus.id_ready && !bus.brTaken;

  fifo_ptr_ctrl #(
    .Depth (Depth)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rstn     (rstn),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (bus.brTaken),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= '{pc: bus.if_pc, instr: bus.if_instr};
    end
  end

  // Empty head reads as PC 0 / NOP rather than stale storage.
  always_comb begin
    bus.id_valid = !w_empty;
    bus.id_pc    = '0;
    bus.id_instr = '0;
    if (!w_empty) begin
      bus.id_pc    = r_mem[w_rd_ptr].pc;
      bus.id_instr = r_mem[w_rd_ptr].instr;
    end
  end

  assign bus.freeze = w_full;
  assign bus.count  = w_count;

endmodule
